// File: rtl/br_pkg.sv
// Shared types and constants for the branch resolver: per-stage prediction
// payload, predictor training packet, and redirect FSM states.
package br_pkg;

    localparam int BR_PC_W        = 32;
    localparam int BR_HIST_W      = 4;
    localparam int DELAY_SLOT_OFS = 8;

    typedef struct packed {
        logic                 valid;
        logic                 pred;
        logic [BR_HIST_W-1:0] hist;
    } br_stage_t;

    typedef struct packed {
        logic                 valid;
        logic [BR_PC_W-1:0]   pc;
        logic                 taken;
        logic                 pred;
        logic [BR_HIST_W-1:0] hist;
    } br_upd_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } br_state_t;

    // Sequential fall-through after a not-taken branch skips the delay slot;
    // the add wraps modulo 2^BR_PC_W by construction.
    function automatic logic [BR_PC_W-1:0] fallthrough_pc(input logic [BR_PC_W-1:0] pc);
        return pc + BR_PC_W'(DELAY_SLOT_OFS);
    endfunction

endpackage

// File: rtl/br_stage_reg.sv
// One pipeline slot of prediction metadata; holds on stall, clear drops only
// the valid bit and wins over hold.
module br_stage_reg
    import br_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      hold,
    input  logic      clear,
    input  br_stage_t d,
    output br_stage_t q
);

    // NOTE: sequential state uses non-blocking assignments so every stage
    // register samples its neighbour's pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clear) begin
            q.valid <= 1'b0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Carries F-stage predictions to M, redirects fetch on a mispredict and trains
// the predictor. Optional BR_PERF_CNT_EN adds saturating branch/mispredict counters.
module branch_resolver
    import br_pkg::*;
#(
    parameter int PC_W   = BR_PC_W,
    parameter int HIST_W = BR_HIST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush_exc,
    input  logic              pred_taken_f,
    input  logic [HIST_W-1:0] hist_f,
    input  logic              branch_d,
    input  logic [PC_W-1:0]   pc_e,
    input  logic [PC_W-1:0]   target_e,
    input  logic              taken_e,
    output logic              mispredict,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              flush_de,
    output logic              upd_valid,
    output logic [PC_W-1:0]   upd_pc,
    output logic              upd_taken,
    output logic              upd_pred,
    output logic [HIST_W-1:0] upd_hist
`ifdef BR_PERF_CNT_EN
    ,
    output logic [31:0]       perf_branches,
    output logic [31:0]       perf_mispred
`endif
);

    br_stage_t f_in, d_q, e_in, e_q, m_q;

    assign f_in = '{valid: 1'b1, pred: pred_taken_f, hist: hist_f};
    // A slot killed by an exception flush cannot launch a branch into E.
    assign e_in = '{valid: branch_d & d_q.valid, pred: d_q.pred, hist: d_q.hist};

    br_stage_reg u_fd (.clk(clk), .rst(rst), .hold(stall), .clear(flush_exc),
                       .d(f_in), .q(d_q));
    br_stage_reg u_de (.clk(clk), .rst(rst), .hold(stall), .clear(flush_exc | flush_de),
                       .d(e_in), .q(e_q));
    br_stage_reg u_em (.clk(clk), .rst(rst), .hold(stall), .clear(flush_exc),
                       .d(e_q), .q(m_q));

    logic [PC_W-1:0] pc_m, target_m;
    logic            taken_m;

    // NOTE: resolution datapath carries no reset; it is only observed while
    // m_q.valid, which is reset.
    always_ff @(posedge clk) begin
        if (!stall) begin
            pc_m     <= pc_e;
            target_m <= target_e;
            taken_m  <= taken_e;
        end
    end

    logic            mis_m;
    logic [PC_W-1:0] correct_pc;
    logic            fire_upd;

    assign mis_m      = m_q.valid & (taken_m ^ m_q.pred);
    assign correct_pc = taken_m ? target_m : fallthrough_pc(pc_m);
    assign fire_upd   = m_q.valid & ~stall & ~flush_exc;

    br_state_t       state, state_nx;
    logic [PC_W-1:0] held_pc;
    logic            latch_pc;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nx    = state;
        mispredict  = 1'b0;
        redirect_pc = '0;
        latch_pc    = 1'b0;
        unique case (state)
            IDLE: begin
                if (mis_m && !flush_exc) begin
                    if (stall) begin
                        latch_pc = 1'b1;
                        state_nx = HOLD;
                    end else begin
                        mispredict  = 1'b1;
                        redirect_pc = correct_pc;
                    end
                end
            end
            HOLD: begin
                if (flush_exc) begin
                    state_nx = IDLE;
                end else if (!stall) begin
                    mispredict  = 1'b1;
                    redirect_pc = held_pc;
                    state_nx    = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign flush_de = mispredict;

    br_upd_t upd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            held_pc <= '0;
            upd_q   <= '0;
        end else begin
            state       <= state_nx;
            if (latch_pc) held_pc <= correct_pc;
            upd_q.valid <= fire_upd;
            if (fire_upd) begin
                upd_q.pc    <= pc_m;
                upd_q.taken <= taken_m;
                upd_q.pred  <= m_q.pred;
                upd_q.hist  <= m_q.hist;
            end
        end
    end

    assign upd_valid = upd_q.valid;
    assign upd_pc    = upd_q.pc;
    assign upd_taken = upd_q.taken;
    assign upd_pred  = upd_q.pred;
    assign upd_hist  = upd_q.hist;

`ifdef BR_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches <= '0;
            perf_mispred  <= '0;
        end else if (upd_valid) begin
            if (perf_branches != '1) perf_branches <= perf_branches + 32'd1;
            if ((upd_taken ^ upd_pred) && perf_mispred != '1)
                perf_mispred <= perf_mispred + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver; define BR_PERF_CNT_EN to
// also exercise the performance counters.
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        rst, stall, flush_exc, pred_taken_f, branch_d, taken_e;
    logic [3:0]  hist_f;
    logic [31:0] pc_e, target_e;
    logic        mispredict, flush_de, upd_valid, upd_taken, upd_pred;
    logic [31:0] redirect_pc, upd_pc;
    logic [3:0]  upd_hist;
`ifdef BR_PERF_CNT_EN
    logic [31:0] perf_branches, perf_mispred;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolver dut (
        .clk(clk), .rst(rst), .stall(stall), .flush_exc(flush_exc),
        .pred_taken_f(pred_taken_f), .hist_f(hist_f), .branch_d(branch_d),
        .pc_e(pc_e), .target_e(target_e), .taken_e(taken_e),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .flush_de(flush_de),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_pred(upd_pred), .upd_hist(upd_hist)
`ifdef BR_PERF_CNT_EN
        , .perf_branches(perf_branches), .perf_mispred(perf_mispred)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walks one branch F->D->E; returns at the start of the cycle it sits in M.
    task automatic issue(input logic pred, input logic [3:0] h, input logic taken,
                         input logic [31:0] pc, input logic [31:0] tgt);
        pred_taken_f = pred; hist_f = h;
        tick();
        pred_taken_f = 1'b0; hist_f = 4'h0; branch_d = 1'b1;
        tick();
        branch_d = 1'b0; pc_e = pc; target_e = tgt; taken_e = taken;
        tick();
        pc_e = '0; target_e = '0; taken_e = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush_exc = 1'b0; pred_taken_f = 1'b0;
        hist_f = 4'h0; branch_d = 1'b0; pc_e = '0; target_e = '0; taken_e = 1'b0;
        tick(); tick();
        @(negedge clk);
        check("reset_mispredict", 32'(mispredict), 32'd0);
        check("reset_redirect",   redirect_pc,     32'd0);
        check("reset_upd_valid",  32'(upd_valid),  32'd0);
        check("reset_upd_pc",     upd_pc,          32'd0);
        rst = 1'b0;
        tick(); tick();

        // Correctly predicted taken branch: training only.
        issue(1'b1, 4'hA, 1'b1, 32'h100, 32'h180);
        @(negedge clk);
        check("ok_no_mispredict", 32'(mispredict), 32'd0);
        tick();
        @(negedge clk);
        check("ok_no_mispredict_late", 32'(mispredict), 32'd0);
        check("ok_upd_valid", 32'(upd_valid), 32'd1);
        check("ok_upd_pc",    upd_pc,         32'h100);
        check("ok_upd_taken", 32'(upd_taken), 32'd1);
        check("ok_upd_pred",  32'(upd_pred),  32'd1);
        check("ok_upd_hist",  32'(upd_hist),  32'hA);
        tick();
        @(negedge clk);
        check("ok_upd_pulse", 32'(upd_valid), 32'd0);

        // Predicted taken, actually not taken: redirect to pc+8.
        issue(1'b1, 4'h3, 1'b0, 32'h200, 32'h300);
        @(negedge clk);
        check("nt_mispredict", 32'(mispredict), 32'd1);
        check("nt_redirect",   redirect_pc,     32'h208);
        check("nt_flush_de",   32'(flush_de),   32'd1);
        tick();
        @(negedge clk);
        check("nt_one_shot",  32'(mispredict), 32'd0);
        check("nt_upd_valid", 32'(upd_valid),  32'd1);
        check("nt_upd_taken", 32'(upd_taken),  32'd0);
        check("nt_upd_pred",  32'(upd_pred),   32'd1);
        check("nt_upd_hist",  32'(upd_hist),   32'h3);
        tick();

        // Predicted not taken, actually taken, stall held 3 cycles in M.
        issue(1'b0, 4'h5, 1'b1, 32'h300, 32'h400);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_no_pulse", 32'(mispredict), 32'd0);
            check("stall_no_upd",   32'(upd_valid),  32'd0);
            tick();
        end
        stall = 1'b0;
        @(negedge clk);
        check("stall_mispredict", 32'(mispredict), 32'd1);
        check("stall_redirect",   redirect_pc,     32'h400);
        tick();
        @(negedge clk);
        check("stall_one_shot",   32'(mispredict), 32'd0);
        check("stall_upd_valid",  32'(upd_valid),  32'd1);
        check("stall_upd_pc",     upd_pc,          32'h300);
        check("stall_upd_taken",  32'(upd_taken),  32'd1);
        check("stall_upd_pred",   32'(upd_pred),   32'd0);
        tick();
        @(negedge clk);
        check("stall_upd_pulse",  32'(upd_valid),  32'd0);

        // Exception arrives while the redirect is parked in HOLD.
        issue(1'b1, 4'h1, 1'b0, 32'h500, 32'h0);
        stall = 1'b1;
        @(negedge clk);
        check("exc_hold_no_pulse", 32'(mispredict), 32'd0);
        tick();
        flush_exc = 1'b1;
        @(negedge clk);
        check("exc_flush_no_pulse", 32'(mispredict), 32'd0);
        tick();
        flush_exc = 1'b0; stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("exc_after_no_pulse", 32'(mispredict), 32'd0);
            check("exc_after_no_upd",   32'(upd_valid),  32'd0);
            tick();
        end

        // PC wrap on the delay-slot add; also shows the FSM is back in IDLE.
        issue(1'b1, 4'h0, 1'b0, 32'hFFFF_FFFC, 32'h0);
        @(negedge clk);
        check("wrap_mispredict", 32'(mispredict), 32'd1);
        check("wrap_redirect",   redirect_pc,     32'h0000_0004);
        tick();
        tick();

        // Exception in the same cycle as a mispredict in M.
        issue(1'b0, 4'h7, 1'b1, 32'h600, 32'h700);
        flush_exc = 1'b1;
        @(negedge clk);
        check("excmis_no_pulse", 32'(mispredict), 32'd0);
        tick();
        flush_exc = 1'b0;
        @(negedge clk);
        check("excmis_no_upd",   32'(upd_valid),  32'd0);
        check("excmis_no_pulse2", 32'(mispredict), 32'd0);
        tick();

        // Reset while a redirect is held.
        issue(1'b1, 4'h2, 1'b0, 32'h800, 32'h0);
        stall = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rsthold_no_pulse", 32'(mispredict), 32'd0);
            check("rsthold_no_upd",   32'(upd_valid),  32'd0);
            tick();
        end

`ifdef BR_PERF_CNT_EN
        // Ten branches, mispredicts at positions 2, 5 and 8.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            issue(1'b1, 4'h0, !(i == 2 || i == 5 || i == 8), 32'h1000 + 32'(i) * 32'h10, 32'h2000);
            tick();
        end
        tick();
        @(negedge clk);
        check("perf_branches", perf_branches, 32'd10);
        check("perf_mispred",  perf_mispred,  32'd3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("perf_branches_rst", perf_branches, 32'd0);
        check("perf_mispred_rst",  perf_mispred,  32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
